// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Single-word fills from instruction memory on a miss.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t state;
  state_t nxt;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];
  logic [29:0]      missaddr;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] missidx;
  logic [TAG_W-1:0] misstag;
  logic             lookup_hit;
  logic             miss;
  logic             fill_done;
  logic             unused_ok;

  assign idx       = imemaddr[IDX_W+1:2];
  assign tag       = imemaddr[31:IDX_W+2];
  assign missidx   = missaddr[IDX_W-1:0];
  assign misstag   = missaddr[29:IDX_W];
  assign unused_ok = ^imemaddr[1:0];

  assign lookup_hit = valid[idx] && (tags[idx] == tag);
  assign ihit       = imemREN && (state == IDLE)
                      && lookup_hit && !RST;
  assign miss       = imemREN && (state == IDLE)
                      && !lookup_hit;
  assign imemload   = data[idx];
  assign iaddr      = {missaddr, 2'b00};

  // Next-state and memory request decode.
  always_comb begin
    nxt       = state;
    iREN      = 1'b0;
    fill_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss) nxt = FILL;
      end
      FILL: begin
        iREN = 1'b1;
        if (!iwait) begin
          nxt       = IDLE;
          fill_done = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  // Capture the word address of a miss; held for the whole fill.
  always_ff @(posedge CLK) begin
    if (RST)       missaddr <= '0;
    else if (miss) missaddr <= imemaddr[31:2];
  end

  // Valid bits: flush beats a completing fill.
  always_ff @(posedge CLK) begin
    if (RST || iflush)  valid <= '0;
    else if (fill_done) valid[missidx] <= 1'b1;
  end

  // Tag and data arrays, written only on fill completion.
  always_ff @(posedge CLK) begin
    if (fill_done && !RST) begin
      tags[missidx] <= misstag;
      data[missidx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: per-cycle vector table
// plus hand-written flush, retarget and reset sequences.
module tb_icache;

  logic        CLK;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int nchk;
  int nerr;

  typedef struct {
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        flush;
    logic        wt;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vecs[$];

  icache #(.SETS(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .iflush   (iflush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  function automatic vec_t mk(
    input logic rst, input logic ren,
    input logic [31:0] addr, input logic flush,
    input logic wt, input logic [31:0] ld,
    input logic e_hit, input logic [31:0] e_load,
    input logic e_ren, input logic [31:0] e_iaddr);
    vec_t v;
    v.rst = rst; v.ren = ren; v.addr = addr;
    v.flush = flush; v.wt = wt; v.ld = ld;
    v.e_hit = e_hit; v.e_load = e_load;
    v.e_ren = e_ren; v.e_iaddr = e_iaddr;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ren,
                       input logic [31:0] addr,
                       input logic flush, input logic wt,
                       input logic [31:0] ld);
    RST = rst; imemREN = ren; imemaddr = addr;
    iflush = flush; iwait = wt; iload = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic outs(input string nm, input logic e_hit,
                      input logic [31:0] e_load,
                      input logic e_ren,
                      input logic [31:0] e_iaddr);
    chk({nm, " ihit"}, {31'd0, ihit}, {31'd0, e_hit});
    if (e_hit) chk({nm, " imemload"}, imemload, e_load);
    chk({nm, " iREN"}, {31'd0, iREN}, {31'd0, e_ren});
    chk({nm, " iaddr"}, iaddr, e_iaddr);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    drive(1, 0, 0, 0, 1, JUNK);

    // reset
    vecs.push_back(mk(1,1,32'h4,0,1,JUNK, 0,0,0,32'h0));
    vecs.push_back(mk(1,0,32'h0,0,1,JUNK, 0,0,0,32'h0));
    // cold miss on 0x4, two wait cycles
    vecs.push_back(mk(0,1,32'h4,0,1,JUNK, 0,0,0,32'h0));
    vecs.push_back(mk(0,1,32'h4,0,1,JUNK, 0,0,1,32'h4));
    vecs.push_back(mk(0,1,32'h4,0,1,JUNK, 0,0,1,32'h4));
    vecs.push_back(mk(0,1,32'h4,0,0,32'h2001_0005, 0,0,1,32'h4));
    vecs.push_back(mk(0,1,32'h4,0,1,JUNK, 1,32'h2001_0005,0,32'h4));
    // fill 0x0, zero wait cycles
    vecs.push_back(mk(0,1,32'h0,0,1,JUNK, 0,0,0,32'h4));
    vecs.push_back(mk(0,1,32'h0,0,0,32'h2001_0001, 0,0,1,32'h0));
    vecs.push_back(mk(0,1,32'h0,0,1,JUNK, 1,32'h2001_0001,0,32'h0));
    // fill 0x8, one wait cycle
    vecs.push_back(mk(0,1,32'h8,0,1,JUNK, 0,0,0,32'h0));
    vecs.push_back(mk(0,1,32'h8,0,1,JUNK, 0,0,1,32'h8));
    vecs.push_back(mk(0,1,32'h8,0,0,32'h2001_0009, 0,0,1,32'h8));
    vecs.push_back(mk(0,1,32'h8,0,1,JUNK, 1,32'h2001_0009,0,32'h8));
    // steady hits, one per cycle; byte offset ignored
    vecs.push_back(mk(0,1,32'h0,0,1,JUNK, 1,32'h2001_0001,0,32'h8));
    vecs.push_back(mk(0,1,32'h4,0,1,JUNK, 1,32'h2001_0005,0,32'h8));
    vecs.push_back(mk(0,1,32'h8,0,1,JUNK, 1,32'h2001_0009,0,32'h8));
    vecs.push_back(mk(0,1,32'h7,0,1,JUNK, 1,32'h2001_0005,0,32'h8));
    vecs.push_back(mk(0,1,32'h0,0,1,JUNK, 1,32'h2001_0001,0,32'h8));
    // conflict: 0x40 evicts 0x0
    vecs.push_back(mk(0,1,32'h40,0,1,JUNK, 0,0,0,32'h8));
    vecs.push_back(mk(0,1,32'h40,0,0,32'h2001_0041, 0,0,1,32'h40));
    vecs.push_back(mk(0,1,32'h40,0,1,JUNK, 1,32'h2001_0041,0,32'h40));
    vecs.push_back(mk(0,1,32'h0,0,1,JUNK, 0,0,0,32'h40));
    vecs.push_back(mk(0,1,32'h0,0,0,32'h2001_0001, 0,0,1,32'h0));
    vecs.push_back(mk(0,1,32'h0,0,1,JUNK, 1,32'h2001_0001,0,32'h0));
    // no request: no hit, no fill
    vecs.push_back(mk(0,0,32'h0,0,1,JUNK, 0,0,0,32'h0));
    vecs.push_back(mk(0,0,32'h30,0,1,JUNK, 0,0,0,32'h0));

    tick();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ren, vecs[i].addr,
            vecs[i].flush, vecs[i].wt, vecs[i].ld);
      outs($sformatf("row%0d", i), vecs[i].e_hit,
           vecs[i].e_load, vecs[i].e_ren, vecs[i].e_iaddr);
      tick();
    end

    // flush with 0x4 cached, then refill
    drive(0, 1, 32'h4, 1, 1, JUNK);
    outs("fl0", 1, 32'h2001_0005, 0, 32'h0);
    tick();
    drive(0, 1, 32'h4, 0, 1, JUNK);
    outs("fl1", 0, 0, 0, 32'h0);
    tick();
    drive(0, 1, 32'h4, 0, 0, 32'h2001_0005);
    outs("fl2", 0, 0, 1, 32'h4);
    tick();
    drive(0, 1, 32'h4, 0, 1, JUNK);
    outs("fl3", 1, 32'h2001_0005, 0, 32'h4);
    tick();

    // flush on the fill-completion cycle wins
    drive(0, 1, 32'h8, 0, 1, JUNK);
    outs("fc0", 0, 0, 0, 32'h4);
    tick();
    drive(0, 1, 32'h8, 1, 0, 32'h2001_0009);
    outs("fc1", 0, 0, 1, 32'h8);
    tick();
    drive(0, 1, 32'h8, 0, 1, JUNK);
    outs("fc2", 0, 0, 0, 32'h8);
    tick();
    drive(0, 1, 32'h8, 0, 0, 32'h2001_0009);
    outs("fc3", 0, 0, 1, 32'h8);
    tick();
    drive(0, 1, 32'h8, 0, 1, JUNK);
    outs("fc4", 1, 32'h2001_0009, 0, 32'h8);
    tick();

    // address change during fill does not retarget
    drive(0, 1, 32'h10, 0, 1, JUNK);
    outs("mv0", 0, 0, 0, 32'h8);
    tick();
    drive(0, 1, 32'h20, 0, 1, JUNK);
    outs("mv1", 0, 0, 1, 32'h10);
    tick();
    drive(0, 0, 32'h20, 0, 0, 32'h2001_0011);
    outs("mv2", 0, 0, 1, 32'h10);
    tick();
    drive(0, 1, 32'h20, 0, 1, JUNK);
    outs("mv3", 0, 0, 0, 32'h10);
    tick();
    drive(0, 1, 32'h10, 0, 0, 32'h2001_0021);
    outs("mv4", 0, 0, 1, 32'h20);
    tick();
    drive(0, 1, 32'h10, 0, 1, JUNK);
    outs("mv5", 1, 32'h2001_0011, 0, 32'h20);
    tick();
    drive(0, 1, 32'h20, 0, 1, JUNK);
    outs("mv6", 1, 32'h2001_0021, 0, 32'h20);
    tick();

    // reset in a fill cycle with iwait=0
    drive(0, 1, 32'h30, 0, 1, JUNK);
    outs("rf0", 0, 0, 0, 32'h20);
    tick();
    drive(0, 1, 32'h30, 0, 1, JUNK);
    outs("rf1", 0, 0, 1, 32'h30);
    tick();
    drive(1, 1, 32'h30, 0, 0, 32'h2001_0031);
    chk("rf2 ihit", {31'd0, ihit}, 32'd0);
    tick();
    drive(0, 1, 32'h30, 0, 1, JUNK);
    outs("rf3", 0, 0, 0, 32'h0);
    tick();
    drive(0, 1, 32'h30, 0, 0, 32'h2001_0031);
    outs("rf4", 0, 0, 1, 32'h30);
    tick();
    drive(0, 1, 32'h30, 0, 1, JUNK);
    outs("rf5", 1, 32'h2001_0031, 0, 32'h30);
    tick();
    drive(0, 1, 32'h10, 0, 1, JUNK);
    outs("rf6", 0, 0, 0, 32'h30);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache sitting directly downstream of the fetch stage: it takes the fetch stage's `imemaddr` and returns the instruction word with a hit flag. On a miss it runs a single-word fill from instruction memory through a wait-state handshake. The fetch stage holds `pcen` low until `ihit` is asserted, so the fetch address stays stable across a fill. Lines are one 32-bit word each; the address is split into tag, index and 2-bit byte offset.

## Interface
Parameters:
- `SETS`, default 16: number of lines; must be a power of two. `IDX_W = log2(SETS)`. `TAG_W = 30 - IDX_W`.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `imemREN`  in  1  fetch requests an instruction this cycle.
- `imemaddr`  in  32  fetch address. Bits [1:0] are ignored, index = [IDX_W+1:2], tag = [31:IDX_W+2].
- `iflush`  in  1  one-cycle pulse; invalidates all lines.
- `ihit`  out  1  `imemload` is valid for the current `imemaddr`.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  read request to instruction memory.
- `iaddr`  out  32  memory word address, with bits [1:0] = 0.
- `iwait`  in  1  memory busy. Read data is valid in the cycle where `iREN=1` and `iwait=0`.
- `iload`  in  32  memory read data.

## Operation
- **Storage:** per line, `valid` (1 bit), `tag` (TAG_W bits) and `data` (32 bits). `valid` is cleared by reset and by `iflush`; `tag` and `data` are not reset.
- **Hit (combinational):** `ihit = imemREN & (state==IDLE) & valid[idx] & (tag[idx]==imemaddr tag)`. `imemload = data[idx]`, meaningful only when `ihit=1`.
- **State machine, IDLE / FILL:**
  - **IDLE:**
    - If `imemREN` and not a hit: latch `imemaddr[31:2]` into `missaddr` and go to FILL.
    - Otherwise stay in IDLE.
    - `iREN=0`.
  - **FILL:**
    - `iREN=1` and `iaddr = {missaddr, 2'b00}`.
    - While `iwait=1`: stay in FILL.
    - When `iwait=0`: write `data[missidx]=iload`, `tag[missidx]=misstag`, `valid[missidx]=1`, then go to IDLE.
    - `ihit=0` throughout FILL.
- **Latched fill address:** the fill always uses `missaddr`. A change of `imemaddr` or a drop of `imemREN` during FILL does not abort or retarget the fill. After returning to IDLE the current address is looked up again.
- **Eviction:** a fill overwrites whatever line was at that index. No write-back, because the cache is read-only.
- **`iflush`:**
  - Clears every `valid` bit at the next edge.
  - In IDLE, `ihit` is unaffected in the same cycle and is 0 from the next cycle.
  - In FILL, the fill continues to completion. If `iflush` coincides with the fill-completion cycle, the flush wins and the line is left invalid.
- **`iaddr` when `iREN=0`:** holds `{missaddr, 2'b00}`.

## Timing
- Reset values: state=IDLE, all `valid`=0, `missaddr`=0. As a result `ihit=0`, `iREN=0`, `iaddr=0`. While `RST=1`, `ihit` is forced to 0.
- Reset during FILL: state returns to IDLE and `iREN` drops in the next cycle. No line is written, even if `iwait=0` in that same cycle.
- Hit latency: 0 cycles. `ihit` is asserted in the same cycle as the request.
- Miss latency with N wait cycles (N ≥ 0):
  - Cycle 0: miss detected, `ihit=0`.
  - Cycles 1..N+1: FILL, with `iREN=1`.
  - Cycle N+2: IDLE, `ihit=1`.
- Back-to-back hits sustain one instruction per cycle.

## Test plan
- **Cold miss:** after reset, `imemREN=1`, `imemaddr=0x0000_0004`, memory holds `0x2001_0005` with 2 wait cycles. Required: `ihit=0` in cycle 0; `iREN=1` with `iaddr=0x4` in cycles 1–3; `ihit=1` with `imemload=0x2001_0005` in cycle 4.
- **Steady hits:** after filling 0x0, 0x4 and 0x8, sweep those addresses on consecutive cycles. Required: `ihit=1` every cycle, `iREN` stays 0, data matches memory.
- **Conflict (SETS=16):** fill 0x0, then request 0x40 (same index 0, different tag). Required: a miss and a fill of 0x40; afterwards 0x0 misses again.
- **Flush:** with 0x4 cached, pulse `iflush`, then request 0x4. Required: a miss and a refill. Separately, assert `iflush` on the fill-completion cycle; the next lookup of that address must miss.
- **Address change mid-fill:** miss on 0x10, then switch `imemaddr` to 0x20 during FILL. Required: `iaddr` stays 0x10 through the fill; afterwards 0x10 is valid and 0x20 misses.
- **Reset mid-fill:** assert `RST` in a FILL cycle that has `iwait=0`. Required: `iREN=0` and `ihit=0` in the next cycle, and the line is not installed.
